conv_requant: RTL and testbench

CONV_REQUANT -- requirements
Module: conv_requant

---
 rtl/conv_requant.sv | 182 ++++++++++++++++++
 tb/tb_conv_requant.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_requant.sv
// Requantization back end for the conv engine: accumulates per-channel 3x3
// partial sums into one output pixel, then bias, rounding shift, optional
// ReLU and int8 saturation through a four-stage pipeline.
//
// state | meaning
// IDLE  | waiting for start; config registers may be loaded
// RUN   | accepting partial sums, emitting pixels into the pipeline
// DRAIN | all pixels issued; waiting for the pipeline to empty
module conv_requant #(
  parameter int CH_W  = 10,
  parameter int PIX_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [CH_W-1:0]  cfg_num_ch,
  input  logic [PIX_W-1:0] cfg_num_pix,
  input  logic [15:0]      cfg_bias,
  input  logic [4:0]       cfg_shift,
  input  logic             cfg_relu,
  input  logic             vld_i,
  input  logic [19:0]      acc_i,
  output logic             vld_o,
  output logic [7:0]       data_o,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    ch_cnt_q, ch_cnt_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [29:0]        psum_q, psum_d;
  logic [CH_W-1:0]    num_ch_q, num_ch_d;
  logic [PIX_W-1:0]   num_pix_q, num_pix_d;
  logic [15:0]        bias_q, bias_d;
  logic [4:0]         shift_q, shift_d;
  logic               relu_q, relu_d;
  logic [29:0]        s1_q, s1_d;
  logic [30:0]        s2_q, s2_d;
  logic [31:0]        s3_q, s3_d;
  logic [7:0]         data_q, data_d;
  logic               s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic               s3_vld_q, s3_vld_d, s4_vld_q, s4_vld_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [29:0]        acc_ext, sum_next;
  logic [CH_W-1:0]    last_ch;
  logic               accept, final_ch, final_pix, pipe_empty;
  logic [31:0]        s2_ext, rnd;
  logic signed [31:0] s3_sum, s3_shr, s3_s;
  logic [7:0]         sat;

  // Next-state, counters, config capture and pipeline stage computation.
  always_comb begin
    state_d   = state_q;
    ch_cnt_d  = ch_cnt_q;
    pix_cnt_d = pix_cnt_q;
    psum_d    = psum_q;
    num_ch_d  = num_ch_q;
    num_pix_d = num_pix_q;
    bias_d    = bias_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    done_d    = 1'b0;

    acc_ext    = {{10{acc_i[19]}}, acc_i};
    // A channel count of zero behaves like one channel.
    last_ch    = (num_ch_q == '0) ? '0 : num_ch_q - CH_W'(1);
    accept     = (state_q == RUN) && vld_i;
    final_ch   = accept && (ch_cnt_q == last_ch);
    final_pix  = final_ch && (pix_cnt_q == num_pix_q - PIX_W'(1));
    sum_next   = (ch_cnt_q == '0) ? acc_ext : psum_q + acc_ext;
    pipe_empty = !(s1_vld_q || s2_vld_q || s3_vld_q || s4_vld_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          num_ch_d  = cfg_num_ch;
          num_pix_d = cfg_num_pix;
          bias_d    = cfg_bias;
          shift_d   = cfg_shift;
          relu_d    = cfg_relu;
          ch_cnt_d  = '0;
          pix_cnt_d = '0;
          state_d   = (cfg_num_pix == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          psum_d   = sum_next;
          ch_cnt_d = final_ch ? '0 : ch_cnt_q + CH_W'(1);
          if (final_ch) pix_cnt_d = pix_cnt_q + PIX_W'(1);
          if (final_pix) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    s1_vld_d = final_ch;
    s1_d     = final_ch ? sum_next : s1_q;

    s2_vld_d = s1_vld_q;
    s2_d     = s1_vld_q ? ({s1_q[29], s1_q} + {{15{bias_q[15]}}, bias_q}) : s2_q;

    // Round half up: add half an LSB of the result before the arithmetic shift.
    s2_ext   = {s2_q[30], s2_q};
    rnd      = 32'd1 << (shift_q - 5'd1);
    s3_sum   = s2_ext + rnd;
    s3_shr   = s3_sum >>> shift_q;
    s3_vld_d = s2_vld_q;
    s3_d     = s2_vld_q ? ((shift_q == 5'd0) ? s2_ext : s3_shr) : s3_q;

    s3_s = s3_q;
    if (relu_q && s3_q[31])   sat = 8'h00;
    else if (s3_s > 32'sd127)  sat = 8'h7F;
    else if (s3_s < -32'sd128) sat = 8'h80;
    else                       sat = s3_q[7:0];
    s4_vld_d = s3_vld_q;
    data_d   = s3_vld_q ? sat : data_q;
  end

  // State and datapath registers; async reset clears everything including config.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ch_cnt_q  <= '0;
      pix_cnt_q <= '0;
      psum_q    <= '0;
      num_ch_q  <= '0;
      num_pix_q <= '0;
      bias_q    <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      data_q    <= '0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
      s4_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_cnt_q  <= ch_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      psum_q    <= psum_d;
      num_ch_q  <= num_ch_d;
      num_pix_q <= num_pix_d;
      bias_q    <= bias_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      data_q    <= data_d;
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      s3_vld_q  <= s3_vld_d;
      s4_vld_q  <= s4_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign vld_o  = s4_vld_q;
  assign data_o = data_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_conv_requant.sv
// Bench for conv_requant: directed scenarios plus randomized jobs, checked
// against an arithmetic reference of the requantization rules.
module tb_conv_requant;
  localparam int CH_W  = 10;
  localparam int PIX_W = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [CH_W-1:0]  cfg_num_ch = '0;
  logic [PIX_W-1:0] cfg_num_pix = '0;
  logic [15:0]      cfg_bias = '0;
  logic [4:0]       cfg_shift = '0;
  logic             cfg_relu = 1'b0;
  logic             vld_i = 1'b0;
  logic [19:0]      acc_i = '0;
  logic             vld_o;
  logic [7:0]       data_o;
  logic             busy;
  logic             done;

  conv_requant #(.CH_W(CH_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_num_ch(cfg_num_ch), .cfg_num_pix(cfg_num_pix), .cfg_bias(cfg_bias),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .vld_i(vld_i), .acc_i(acc_i),
    .vld_o(vld_o), .data_o(data_o), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int val; int cyc;} exp_t;
  exp_t exp_q[$];
  int   exp_done = -1;
  int   last_exp = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference requantization of one finished channel sum.
  function automatic int ref_pix(input longint sum, input int bias, input int shift, input bit relu);
    longint v;
    v = sum + bias;
    if (shift > 0) v = (v + (longint'(1) << (shift - 1))) >>> shift;
    if (relu && v < 0) v = 0;
    else if (v > 127)  v = 127;
    else if (v < -128) v = -128;
    return int'(v);
  endfunction

  // Output observation between edges: expected pixels, data hold and done.
  task automatic observe();
    bit expnow;
    bit expdone;
    if (!rstn) return;
    expnow = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    if (expnow) begin
      chk("vld_o", vld_o, 1);
      chk("data_o", $signed(data_o), exp_q[0].val);
      last_exp = exp_q[0].val;
      void'(exp_q.pop_front());
    end else if (vld_o) begin
      chk("unexp_vld", vld_o, 0);
    end else begin
      chk("data_hold", $signed(data_o), last_exp);
    end
    expdone = (cyc == exp_done);
    if (expdone || done) chk("done", done, expdone);
    if (expdone) exp_done = -1;
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic int rand_acc();
    if ($urandom % 2) return int'($urandom_range(0, 1048575)) - 524288;
    return int'($urandom_range(0, 600)) - 300;
  endfunction

  task automatic run_job(input int nch, input int npix, input int bias, input int shift,
                         input bit relu, input int accs[$], input bit gaps);
    int     eff;
    int     idx;
    longint sum;
    eff = (nch == 0) ? 1 : nch;
    cfg_num_ch  = CH_W'(nch);
    cfg_num_pix = PIX_W'(npix);
    cfg_bias    = 16'(bias);
    cfg_shift   = 5'(shift);
    cfg_relu    = relu;
    start       = 1'b1;
    if (npix == 0) exp_done = cyc + 2;
    step();
    start = 1'b0;
    chk("busy_run", busy, 1);
    cfg_num_ch  = CH_W'($urandom);
    cfg_num_pix = PIX_W'($urandom);
    cfg_bias    = 16'($urandom);
    cfg_shift   = 5'($urandom);
    cfg_relu    = 1'($urandom);
    idx = 0;
    for (int p = 0; p < npix; p++) begin
      sum = 0;
      for (int c = 0; c < eff; c++) begin
        if (gaps) begin
          while ($urandom % 3 == 0) begin
            vld_i = 1'b0;
            acc_i = 20'($urandom);
            start = ($urandom % 6 == 0);
            step();
          end
        end
        vld_i = 1'b1;
        acc_i = 20'(accs[idx]);
        start = gaps && ($urandom % 6 == 0);
        sum += accs[idx];
        idx++;
        if (c == eff - 1) begin
          exp_q.push_back('{val: ref_pix(sum, bias, shift, relu), cyc: cyc + 4});
          if (p == npix - 1) exp_done = cyc + 6;
        end
        step();
      end
    end
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vld_i = 1'($urandom);
      acc_i = 20'($urandom);
      step();
    end
    vld_i = 1'b0;
    chk("queue_empty", exp_q.size(), 0);
    chk("done_pending", exp_done, -1);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int q[$];
    int nch, npix, sh;
    #1;
    chk("rst_vld_o", vld_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #16 rstn = 1'b1;
    @(posedge clk); #1;
    step(); step();

    q = '{100, 200, -50};
    run_job(3, 1, 6, 1, 0, q, 0);

    // Reset after two of three channels, then a fresh job.
    cfg_num_ch = 3; cfg_num_pix = 1; cfg_bias = 0; cfg_shift = 0; cfg_relu = 0;
    start = 1'b1; step(); start = 1'b0;
    vld_i = 1'b1; acc_i = 20'(1000); step();
    acc_i = 20'(2000); step();
    vld_i = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("midrst_vld_o", vld_o, 0);
    chk("midrst_data_o", data_o, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    exp_q.delete(); exp_done = -1; last_exp = 0;
    #10 rstn = 1'b1;
    @(posedge clk); #1;
    step(); step(); step();
    q = '{7, 8, 9};
    run_job(3, 1, 0, 0, 0, q, 0);

    q = '{300, -300};
    run_job(1, 2, 0, 2, 0, q, 0);
    q = '{-5, 1000, 42};
    run_job(1, 3, 0, 0, 1, q, 0);
    q = '{10, 20, -3, -4};
    run_job(2, 2, 0, 0, 0, q, 0);
    q = {};
    run_job(3, 0, 5, 1, 0, q, 1);
    q = '{-77, 64};
    run_job(0, 2, 3, 1, 0, q, 0);

    for (int j = 0; j < 30; j++) begin
      case ($urandom % 5)
        0: nch = 0;
        1: nch = 1;
        2: nch = 2;
        3: nch = 3;
        default: nch = int'($urandom_range(1, 8));
      endcase
      npix = int'($urandom_range(0, 5));
      sh = ($urandom % 2) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 31));
      q = {};
      for (int k = 0; k < ((nch == 0) ? 1 : nch) * npix; k++) q.push_back(rand_acc());
      run_job(nch, npix, int'($urandom_range(0, 65535)) - 32768, sh, 1'($urandom), q, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
